// File: rtl/dco_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dco_pkg
// Purpose  : Shared state encoding, matrix defaults and code-range helper for
//            the DCO code encoder and the DCO-side model.
// Revision : 1.0
// ============================================================================
package dco_pkg;

    localparam int DCO_ROWS_DEFAULT       = 17;
    localparam int DCO_COLUMNS_DEFAULT    = 15;
    localparam int DCO_CODE_WIDTH_DEFAULT = 8;
    localparam int DCO_FRAC_BITS_DEFAULT  = 4;
    localparam int DCO_MAX_STEP_DEFAULT   = 4;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        IDLE = 2'd1,
        SLEW = 2'd2
    } dco_state_e;

    // Highest code the matrix can represent: every cell but one switched on.
    function automatic int code_max(input int rows, input int cols);
        return rows * cols - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dco_code_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : dco_code_encoder_if
// Purpose  : Valid/ready code bus from the loop filter into the DCO encoder.
// Revision : 1.0
// ============================================================================
interface dco_code_encoder_if #(
    parameter int CODE_WIDTH = 8,
    parameter int FRAC_BITS  = 4
);
    logic [CODE_WIDTH+FRAC_BITS-1:0] code_in;
    logic                            code_valid;
    logic                            code_ready;

    modport master (
        output code_in,
        output code_valid,
        input  code_ready
    );

    modport slave (
        input  code_in,
        input  code_valid,
        output code_ready
    );
endinterface
`default_nettype wire

// File: rtl/dco_therm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : dco_therm_encoder
// Purpose  : Combinational code -> active-low row/column thermometer selects.
// Revision : 1.0
// ============================================================================
module dco_therm_encoder
    import dco_pkg::*;
#(
    parameter int NUM_DCO_MATRIX_ROWS    = DCO_ROWS_DEFAULT,
    parameter int NUM_DCO_MATRIX_COLUMNS = DCO_COLUMNS_DEFAULT,
    parameter int CODE_WIDTH             = DCO_CODE_WIDTH_DEFAULT
) (
    input  logic [CODE_WIDTH-1:0]             code,
    output logic [NUM_DCO_MATRIX_ROWS-2:0]    row_sel_b,
    output logic [NUM_DCO_MATRIX_COLUMNS-2:0] col_sel_b
);

    localparam logic [CODE_WIDTH-1:0] COLS_W = CODE_WIDTH'(NUM_DCO_MATRIX_COLUMNS);

    logic [CODE_WIDTH-1:0] row_idx;
    logic [CODE_WIDTH-1:0] col_idx;

    assign row_idx = code / COLS_W;
    assign col_idx = code % COLS_W;

    // A select line is released (high) once its index reaches the fill level.
    for (genvar i = 0; i < NUM_DCO_MATRIX_ROWS - 1; i++) begin : g_row
        assign row_sel_b[i] = (row_idx <= CODE_WIDTH'(i));
    end

    for (genvar j = 0; j < NUM_DCO_MATRIX_COLUMNS - 1; j++) begin : g_col
        assign col_sel_b[j] = (col_idx <= CODE_WIDTH'(j));
    end

endmodule
`default_nettype wire

// File: rtl/dco_code_encoder.sv
`default_nettype none
// ============================================================================
// Module   : dco_code_encoder
// Purpose  : Slew-limited code to row/column thermometer drive, sleep sequencing
//            and optional sigma-delta dither (enabled by macro DCO_DITHER_EN).
// Revision : 1.0
// ============================================================================
module dco_code_encoder
    import dco_pkg::*;
#(
    parameter int NUM_DCO_MATRIX_ROWS    = DCO_ROWS_DEFAULT,
    parameter int NUM_DCO_MATRIX_COLUMNS = DCO_COLUMNS_DEFAULT,
    parameter int CODE_WIDTH             = DCO_CODE_WIDTH_DEFAULT,
    parameter int FRAC_BITS              = DCO_FRAC_BITS_DEFAULT,
    parameter int MAX_STEP               = DCO_MAX_STEP_DEFAULT
) (
    input  logic                              clock,
    input  logic                              reset_b,
    input  logic                              enable,
    dco_code_encoder_if.slave                 code_bus,
    output logic [NUM_DCO_MATRIX_ROWS-2:0]    row_sel_b,
    output logic [NUM_DCO_MATRIX_COLUMNS-2:0] col_sel_b,
    output logic                              sleep_b,
    output logic                              dither,
    output logic [CODE_WIDTH-1:0]             current_code,
    output logic                              settled
);

    localparam int CODE_MAX_INT   = code_max(NUM_DCO_MATRIX_ROWS, NUM_DCO_MATRIX_COLUMNS);
    localparam int CODE_LIMIT_INT = (CODE_MAX_INT > (2**CODE_WIDTH) - 1) ? (2**CODE_WIDTH) - 1
                                                                           : CODE_MAX_INT;
    localparam logic [CODE_WIDTH-1:0] CODE_LIMIT = CODE_WIDTH'(CODE_LIMIT_INT);
    localparam logic [CODE_WIDTH-1:0] STEP_LIMIT = CODE_WIDTH'(MAX_STEP);

    dco_state_e                        state_q, state_d;
    logic [CODE_WIDTH-1:0]             target_q, target_d;
    logic [CODE_WIDTH-1:0]             current_code_q, current_code_d;
    logic [NUM_DCO_MATRIX_ROWS-2:0]    row_sel_b_q, row_sel_b_d;
    logic [NUM_DCO_MATRIX_COLUMNS-2:0] col_sel_b_q, col_sel_b_d;
    logic                              sleep_b_q, sleep_b_d;

    logic [CODE_WIDTH-1:0] code_int;
    logic [CODE_WIDTH-1:0] code_sat;
    logic                  slew_up;
    logic [CODE_WIDTH-1:0] slew_gap;
    logic [CODE_WIDTH-1:0] slew_step;
    logic [CODE_WIDTH-1:0] slew_next;
    logic                  accept;

    assign code_int = code_bus.code_in[CODE_WIDTH+FRAC_BITS-1:FRAC_BITS];
    assign code_sat = (code_int > CODE_LIMIT) ? CODE_LIMIT : code_int;

    assign slew_up   = (target_q >= current_code_q);
    assign slew_gap  = slew_up ? (target_q - current_code_q) : (current_code_q - target_q);
    assign slew_step = (slew_gap > STEP_LIMIT) ? STEP_LIMIT : slew_gap;
    assign slew_next = slew_up ? (current_code_q + slew_step) : (current_code_q - slew_step);

    // A code offered in the same cycle that enable drops is never taken.
    assign accept = (state_q == IDLE) && code_bus.code_valid && enable;

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        current_code_d = current_code_q;
        case (state_q)
            OFF: begin
                if (enable) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (accept) begin
                    target_d = code_sat;
                    if (code_sat != current_code_q) begin
                        state_d = SLEW;
                    end
                end
            end
            SLEW: begin
                current_code_d = slew_next;
                if (slew_next == target_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
        if (!enable) begin
            state_d        = OFF;
            target_d       = '0;
            current_code_d = '0;
        end
    end

    assign sleep_b_d = (state_d != OFF);

    dco_therm_encoder #(
        .NUM_DCO_MATRIX_ROWS    (NUM_DCO_MATRIX_ROWS),
        .NUM_DCO_MATRIX_COLUMNS (NUM_DCO_MATRIX_COLUMNS),
        .CODE_WIDTH             (CODE_WIDTH)
    ) u_therm (
        .code      (current_code_d),
        .row_sel_b (row_sel_b_d),
        .col_sel_b (col_sel_b_d)
    );

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q        <= OFF;
            target_q       <= '0;
            current_code_q <= '0;
            row_sel_b_q    <= '1;
            col_sel_b_q    <= '1;
            sleep_b_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            current_code_q <= current_code_d;
            row_sel_b_q    <= row_sel_b_d;
            col_sel_b_q    <= col_sel_b_d;
            sleep_b_q      <= sleep_b_d;
        end
    end

`ifdef DCO_DITHER_EN
    logic [FRAC_BITS-1:0] frac_q, frac_d;
    logic [FRAC_BITS-1:0] acc_q, acc_d;
    logic [FRAC_BITS:0]   acc_sum;
    logic                 dither_q, dither_d;

    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};

    // Accumulate only while parked in IDLE so dither stays quiet on any cycle
    // that is slewing or entering/leaving sleep.
    always_comb begin
        frac_d   = frac_q;
        acc_d    = acc_q;
        dither_d = 1'b0;
        if (state_d == OFF) begin
            frac_d = '0;
            acc_d  = '0;
        end else begin
            if (accept) begin
                frac_d = code_bus.code_in[FRAC_BITS-1:0];
            end
            if ((state_q == IDLE) && (state_d == IDLE)) begin
                acc_d    = acc_sum[FRAC_BITS-1:0];
                dither_d = acc_sum[FRAC_BITS];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            frac_q   <= '0;
            acc_q    <= '0;
            dither_q <= 1'b0;
        end else begin
            frac_q   <= frac_d;
            acc_q    <= acc_d;
            dither_q <= dither_d;
        end
    end

    assign dither = dither_q;
`else
    logic unused_frac;
    assign unused_frac = ^code_bus.code_in[FRAC_BITS-1:0];
    assign dither      = 1'b0;
`endif

    assign code_bus.code_ready = (state_q == IDLE);
    assign settled             = (state_q == IDLE);
    assign sleep_b             = sleep_b_q;
    assign current_code        = current_code_q;
    assign row_sel_b           = row_sel_b_q;
    assign col_sel_b           = col_sel_b_q;

endmodule
`default_nettype wire

// File: tb/tb_dco_code_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dco_code_encoder
// Purpose  : Directed scoreboard bench for dco_code_encoder.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dco_code_encoder;
    import dco_pkg::*;

    localparam int ROWS = 17;
    localparam int COLS = 15;
    localparam int CW   = 8;
    localparam int FB   = 4;
    localparam int CMAX = ROWS * COLS - 1;

    logic          clock   = 1'b0;
    logic          reset_b = 1'b0;
    logic          enable  = 1'b0;
    logic [15:0]   row_sel_b;
    logic [13:0]   col_sel_b;
    logic          sleep_b;
    logic          dither;
    logic [CW-1:0] current_code;
    logic          settled;

    dco_code_encoder_if #(.CODE_WIDTH(CW), .FRAC_BITS(FB)) bus ();

    dco_code_encoder #(
        .NUM_DCO_MATRIX_ROWS    (ROWS),
        .NUM_DCO_MATRIX_COLUMNS (COLS),
        .CODE_WIDTH             (CW),
        .FRAC_BITS              (FB),
        .MAX_STEP               (4)
    ) dut (
        .clock        (clock),
        .reset_b      (reset_b),
        .enable       (enable),
        .code_bus     (bus),
        .row_sel_b    (row_sel_b),
        .col_sel_b    (col_sel_b),
        .sleep_b      (sleep_b),
        .dither       (dither),
        .current_code (current_code),
        .settled      (settled)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int m_cur  = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_row(input int code);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = (i >= code / COLS);
        return r;
    endfunction

    function automatic logic [13:0] exp_col(input int code);
        logic [13:0] c;
        for (int i = 0; i < 14; i++) c[i] = (i >= code % COLS);
        return c;
    endfunction

    task automatic send_code(input int code_int, input int frac);
        int waited;
        waited = 0;
        while (bus.code_ready !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        chk("ready_wait", {31'd0, bus.code_ready}, 32'd1);
        bus.code_in    = 12'((code_int << FB) | frac);
        bus.code_valid = 1'b1;
        tick();
        bus.code_valid = 1'b0;
    endtask

    // Reference slew model: expected code for every cycle until the target.
    task automatic push_traj(input int tgt);
        int t;
        t = (tgt > CMAX) ? CMAX : tgt;
        while (m_cur != t) begin
            int d;
            int s;
            d = (t > m_cur) ? t - m_cur : m_cur - t;
            s = (d > 4) ? 4 : d;
            m_cur = (t > m_cur) ? m_cur + s : m_cur - s;
            exp_q.push_back(m_cur);
        end
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            int e;
            int last;
            tick();
            e    = exp_q.pop_front();
            last = (exp_q.size() == 0) ? 1 : 0;
            chk("slew_code", 32'(current_code), 32'(e));
            chk("slew_row", 32'(row_sel_b), 32'(exp_row(e)));
            chk("slew_col", 32'(col_sel_b), 32'(exp_col(e)));
            chk("slew_settled", {31'd0, settled}, 32'(last));
            chk("slew_ready", {31'd0, bus.code_ready}, 32'(last));
        end
    endtask

    initial begin
        int cnt;
        int last_hi;
        int exp_dither_cnt;
        bus.code_in    = '0;
        bus.code_valid = 1'b0;

        repeat (3) tick();
        chk("rst_sleep", {31'd0, sleep_b}, 32'd0);
        chk("rst_ready", {31'd0, bus.code_ready}, 32'd0);
        chk("rst_settled", {31'd0, settled}, 32'd0);
        chk("rst_code", 32'(current_code), 32'd0);
        chk("rst_row", 32'(row_sel_b), 32'hFFFF);
        chk("rst_col", 32'(col_sel_b), 32'h3FFF);
        chk("rst_dither", {31'd0, dither}, 32'd0);

        reset_b = 1'b1;
        tick();
        chk("off_sleep", {31'd0, sleep_b}, 32'd0);
        enable = 1'b1;
        tick();
        chk("wake_sleep", {31'd0, sleep_b}, 32'd1);
        chk("wake_ready", {31'd0, bus.code_ready}, 32'd1);
        chk("wake_settled", {31'd0, settled}, 32'd1);
        chk("wake_row", 32'(row_sel_b), 32'hFFFF);
        chk("wake_col", 32'(col_sel_b), 32'h3FFF);

        // Slew 0 -> 37.
        send_code(37, 0);
        chk("c37_ready", {31'd0, bus.code_ready}, 32'd0);
        chk("c37_settled", {31'd0, settled}, 32'd0);
        push_traj(37);
        drain(exp_q.size());
        chk("c37_code", 32'(current_code), 32'd37);
        chk("c37_row", 32'(row_sel_b), 32'hFFFC);
        chk("c37_col", 32'(col_sel_b), 32'h3F80);

        // Sleep returns the code to zero; then saturating slew to 254.
        enable = 1'b0;
        tick();
        chk("sleep_code", 32'(current_code), 32'd0);
        m_cur  = 0;
        enable = 1'b1;
        tick();
        send_code(255, 0);
        push_traj(255);
        cnt = exp_q.size();
        drain(cnt);
        chk("sat_cycles", 32'(cnt), 32'd64);
        chk("sat_code", 32'(current_code), 32'd254);
        chk("sat_row", 32'(row_sel_b), 32'h0000);
        chk("sat_col", 32'(col_sel_b), 32'h0000);

        // Drop enable mid-slew at code 20.
        enable = 1'b0;
        tick();
        m_cur  = 0;
        enable = 1'b1;
        tick();
        send_code(100, 4);
        push_traj(100);
        drain(5);
        chk("mid_code", 32'(current_code), 32'd20);
        enable = 1'b0;
        tick();
        exp_q.delete();
        m_cur = 0;
        chk("abort_sleep", {31'd0, sleep_b}, 32'd0);
        chk("abort_code", 32'(current_code), 32'd0);
        chk("abort_row", 32'(row_sel_b), 32'hFFFF);
        chk("abort_col", 32'(col_sel_b), 32'h3FFF);
        chk("abort_ready", {31'd0, bus.code_ready}, 32'd0);

        // A valid pulse while asleep must be ignored.
        bus.code_in    = {8'd50, 4'd0};
        bus.code_valid = 1'b1;
        tick();
        chk("off_ready", {31'd0, bus.code_ready}, 32'd0);
        bus.code_valid = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        chk("off_drop_code", 32'(current_code), 32'd0);
        tick();
        chk("off_drop_code2", 32'(current_code), 32'd0);
        chk("off_drop_settled", {31'd0, settled}, 32'd1);

        // Dither at code 100 with frac 4.
        send_code(100, 4);
        push_traj(100);
        drain(exp_q.size());
`ifdef DCO_DITHER_EN
        exp_dither_cnt = 4;
`else
        exp_dither_cnt = 0;
`endif
        cnt     = 0;
        last_hi = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("dith_code", 32'(current_code), 32'd100);
            if (dither === 1'b1) begin
                if (last_hi >= 0) chk("dith_gap", 32'(i - last_hi), 32'd4);
                last_hi = i;
                cnt++;
            end
        end
        chk("dith_cnt4", 32'(cnt), 32'(exp_dither_cnt));

        // Same code, frac 0: stays in IDLE and never dithers.
        send_code(100, 0);
        chk("f0_settled", {31'd0, settled}, 32'd1);
        chk("f0_ready", {31'd0, bus.code_ready}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (dither === 1'b1) cnt++;
        end
        chk("dith_cnt0", 32'(cnt), 32'd0);
        chk("f0_code", 32'(current_code), 32'd100);

        // New code held during a slew is taken only once IDLE is reached.
        send_code(120, 0);
        push_traj(120);
        drain(2);
        bus.code_in    = {8'd60, 4'd0};
        bus.code_valid = 1'b1;
        drain(exp_q.size());
        chk("hold_code", 32'(current_code), 32'd120);
        tick();
        bus.code_valid = 1'b0;
        chk("hold_accept_ready", {31'd0, bus.code_ready}, 32'd0);
        chk("hold_accept_code", 32'(current_code), 32'd120);
        push_traj(60);
        drain(exp_q.size());
        chk("hold_final", 32'(current_code), 32'd60);
        chk("hold_row", 32'(row_sel_b), 32'hFFF0);
        chk("hold_col", 32'(col_sel_b), 32'h3FFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
